// File: rtl/pcie_ptile_tx_fc.sv
`default_nettype none
// ============================================================================
// Module   : pcie_ptile_tx_fc
// Function : TX flow-control credit gate for the P-Tile tx_st interface.
//            Captures TDM-rotated credit limits, tracks consumption, and
//            grants a request only when header and data credits both suffice.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_ptile_tx_fc #(
    parameter int HDR_CNT_WIDTH  = 12,
    parameter int DATA_CNT_WIDTH = 16,
    parameter int LEN_WIDTH      = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          tx_cdts_limit,
    input  logic [2:0]           tx_cdts_limit_tdm_idx,
    input  logic                 req_valid,
    input  logic [1:0]           req_type,
    input  logic [LEN_WIDTH-1:0] req_len_dw,
    output logic                 req_ready,
    output logic [5:0]           limit_valid,
    output logic                 stall,
    output logic [31:0]          stall_count
);

    localparam logic [HDR_CNT_WIDTH-1:0]  c_hdr_one  = HDR_CNT_WIDTH'(1);
    localparam logic [HDR_CNT_WIDTH-1:0]  c_hdr_half = {1'b1, {(HDR_CNT_WIDTH-1){1'b0}}};
    localparam logic [DATA_CNT_WIDTH-1:0] c_dat_half = {1'b1, {(DATA_CNT_WIDTH-1){1'b0}}};

    // Index 0/1/2 = posted / non-posted / completion
    logic [HDR_CNT_WIDTH-1:0]  r_limit_h [3];
    logic [HDR_CNT_WIDTH-1:0]  r_cons_h  [3];
    logic [DATA_CNT_WIDTH-1:0] r_limit_d [3];
    logic [DATA_CNT_WIDTH-1:0] r_cons_d  [3];
    logic [5:0]                r_limit_valid;
    logic [31:0]               r_stall_count;

    logic [DATA_CNT_WIDTH:0]   w_len_round;
    logic [DATA_CNT_WIDTH-1:0] w_need_d;
    logic [HDR_CNT_WIDTH-1:0]  w_sel_limit_h;
    logic [HDR_CNT_WIDTH-1:0]  w_sel_cons_h;
    logic [DATA_CNT_WIDTH-1:0] w_sel_limit_d;
    logic [DATA_CNT_WIDTH-1:0] w_sel_cons_d;
    logic                      w_sel_valid;
    logic [HDR_CNT_WIDTH-1:0]  w_rem_h;
    logic [DATA_CNT_WIDTH-1:0] w_rem_d;
    logic                      w_grant;
    logic                      w_stall;

    assign w_len_round = (DATA_CNT_WIDTH+1)'(req_len_dw) + (DATA_CNT_WIDTH+1)'(3);
    assign w_need_d    = DATA_CNT_WIDTH'(w_len_round >> 2);

    always_comb begin
        w_sel_limit_h = '0;
        w_sel_cons_h  = '0;
        w_sel_limit_d = '0;
        w_sel_cons_d  = '0;
        w_sel_valid   = 1'b0;
        case (req_type)
            2'd0: begin
                w_sel_limit_h = r_limit_h[0];
                w_sel_cons_h  = r_cons_h[0];
                w_sel_limit_d = r_limit_d[0];
                w_sel_cons_d  = r_cons_d[0];
                w_sel_valid   = r_limit_valid[0] & r_limit_valid[3];
            end
            2'd1: begin
                w_sel_limit_h = r_limit_h[1];
                w_sel_cons_h  = r_cons_h[1];
                w_sel_limit_d = r_limit_d[1];
                w_sel_cons_d  = r_cons_d[1];
                w_sel_valid   = r_limit_valid[1] & r_limit_valid[4];
            end
            2'd2: begin
                w_sel_limit_h = r_limit_h[2];
                w_sel_cons_h  = r_cons_h[2];
                w_sel_limit_d = r_limit_d[2];
                w_sel_cons_d  = r_cons_d[2];
                w_sel_valid   = r_limit_valid[2] & r_limit_valid[5];
            end
            default: w_sel_valid = 1'b0;
        endcase
    end

    // Half-window modular compare: a remainder that "went negative" lands above half
    assign w_rem_h = w_sel_limit_h - w_sel_cons_h - c_hdr_one;
    assign w_rem_d = w_sel_limit_d - w_sel_cons_d - w_need_d;
    assign w_grant = req_valid && w_sel_valid && (w_rem_h <= c_hdr_half) && (w_rem_d <= c_dat_half);
    assign w_stall = req_valid && !w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_limit_h[i] <= '0;
                r_cons_h[i]  <= '0;
                r_limit_d[i] <= '0;
                r_cons_d[i]  <= '0;
            end
            r_limit_valid <= '0;
            r_stall_count <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (tx_cdts_limit_tdm_idx == 3'(i)) begin
                    r_limit_h[i]     <= tx_cdts_limit[HDR_CNT_WIDTH-1:0];
                    r_limit_valid[i] <= 1'b1;
                end
                if (tx_cdts_limit_tdm_idx == 3'(i + 4)) begin
                    r_limit_d[i]         <= tx_cdts_limit[DATA_CNT_WIDTH-1:0];
                    r_limit_valid[i + 3] <= 1'b1;
                end
                if (w_grant && (req_type == 2'(i))) begin
                    r_cons_h[i] <= r_cons_h[i] + c_hdr_one;
                    r_cons_d[i] <= r_cons_d[i] + w_need_d;
                end
            end
            if (w_stall && (r_stall_count != 32'hFFFF_FFFF))
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign req_ready   = w_grant;
    assign stall       = w_stall;
    assign limit_valid = r_limit_valid;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_pcie_ptile_tx_fc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_ptile_tx_fc
// Function : Directed bench for pcie_ptile_tx_fc with a credit-arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_ptile_tx_fc;

    localparam int LW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   tx_cdts_limit;
    logic [2:0]    tx_cdts_limit_tdm_idx;
    logic          req_valid;
    logic [1:0]    req_type;
    logic [LW-1:0] req_len_dw;
    logic          req_ready;
    logic [5:0]    limit_valid;
    logic          stall;
    logic [31:0]   stall_count;

    pcie_ptile_tx_fc #(.HDR_CNT_WIDTH(12), .DATA_CNT_WIDTH(16), .LEN_WIDTH(LW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .tx_cdts_limit         (tx_cdts_limit),
        .tx_cdts_limit_tdm_idx (tx_cdts_limit_tdm_idx),
        .req_valid             (req_valid),
        .req_type              (req_type),
        .req_len_dw            (req_len_dw),
        .req_ready             (req_ready),
        .limit_valid           (limit_valid),
        .stall                 (stall),
        .stall_count           (stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: slots 0..2 header PH/NPH/CPLH, 3..5 data PD/NPD/CPLD
    int     m_lim  [6];
    int     m_cons [6];
    bit     m_valid[6];
    longint m_sc;
    bit     m_live = 1'b0;

    function automatic int pmod(input int x, input int m);
        return ((x % m) + m) % m;
    endfunction

    function automatic int data_need();
        return (int'(req_len_dw) + 3) / 4;
    endfunction

    function automatic bit m_grant();
        int t;
        if (!req_valid) return 1'b0;
        t = int'(req_type);
        if (t > 2) return 1'b0;
        if (!(m_valid[t] && m_valid[t+3])) return 1'b0;
        return (pmod(m_lim[t] - m_cons[t] - 1, 4096) <= 2048) &&
               (pmod(m_lim[t+3] - m_cons[t+3] - data_need(), 65536) <= 32768);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit g;
        int t;
        g = m_grant();
        if (rst) begin
            for (int i = 0; i < 6; i++) begin
                m_lim[i] = 0; m_cons[i] = 0; m_valid[i] = 1'b0;
            end
            m_sc   = 0;
            m_live = 1'b1;
        end else begin
            t = int'(tx_cdts_limit_tdm_idx);
            if (t <= 2) begin
                m_lim[t] = int'(tx_cdts_limit) & 'hFFF; m_valid[t] = 1'b1;
            end else if (t >= 4 && t <= 6) begin
                m_lim[t-1] = int'(tx_cdts_limit); m_valid[t-1] = 1'b1;
            end
            if (g) begin
                t = int'(req_type);
                m_cons[t]   = (m_cons[t] + 1) % 4096;
                m_cons[t+3] = (m_cons[t+3] + data_need()) % 65536;
            end
            if (req_valid && !g && m_sc < 64'hFFFF_FFFF) m_sc++;
        end
    end

    always @(negedge clk) begin
        bit g;
        logic [5:0] mv;
        if (m_live) begin
            g = m_grant();
            for (int i = 0; i < 6; i++) mv[i] = m_valid[i];
            chk("model_ready", longint'(req_ready), longint'(g));
            chk("model_stall", longint'(stall), longint'(req_valid && !g));
            chk("model_limit_valid", longint'(limit_valid), longint'(mv));
            chk("model_stall_count", longint'(stall_count), m_sc);
        end
    end

    // One cycle: drive after the edge, return at the following negedge
    task automatic step(input bit v, input int ty, input int len, input int idx, input int lim);
        @(posedge clk);
        #1;
        req_valid             = v;
        req_type              = 2'(ty);
        req_len_dw            = LW'(len);
        tx_cdts_limit_tdm_idx = 3'(idx);
        tx_cdts_limit         = 16'(lim);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_type = 2'd0; req_len_dw = '0;
        tx_cdts_limit_tdm_idx = 3'd3; tx_cdts_limit = '0;
        step(0, 0, 0, 3, 0);
        step(0, 0, 0, 3, 0);
        rst = 1'b0;

        // No limits delivered: everything stalls
        step(1, 0, 8, 3, 0);
        chk("nolim_ready", req_ready, 0); chk("nolim_sc0", stall_count, 0); chk("nolim_lv", limit_valid, 0);
        step(1, 0, 8, 3, 0);
        chk("nolim_sc1", stall_count, 1);
        step(1, 0, 8, 3, 0);
        chk("nolim_sc2", stall_count, 2); chk("nolim_stall", stall, 1);

        // PH=2, PD=4: two len-8 grants back to back, then PH exhausted
        step(0, 0, 0, 0, 2);
        step(0, 0, 0, 4, 4);
        step(1, 0, 8, 3, 0); chk("p_grant1", req_ready, 1);
        step(1, 0, 8, 3, 0); chk("p_grant2", req_ready, 1);
        step(1, 0, 1, 4, 5); chk("p_ph_empty", req_ready, 0);
        step(1, 0, 1, 0, 3); chk("p_ph_capture_cycle", req_ready, 0);
        step(1, 0, 1, 3, 0); chk("p_ph_after_capture", req_ready, 1);

        // Completion: CPLD missing blocks, CPLD=0 suffices for zero-length
        step(0, 0, 0, 2, 1);
        step(1, 2, 0, 3, 0); chk("c_no_cpld", req_ready, 0);
        step(1, 2, 0, 6, 0); chk("c_cpld_capture", req_ready, 0);
        step(1, 2, 0, 3, 0); chk("c_grant", req_ready, 1);
        step(1, 2, 0, 2, 2); chk("c_cplh_used", req_ready, 0);
        step(1, 2, 0, 3, 0); chk("c_data_unconsumed", req_ready, 1);

        // Same-cycle capture and grant on posted
        step(0, 0, 0, 4, 9);
        step(0, 0, 0, 0, 4);
        step(1, 0, 4, 0, 5); chk("s_old_limit_grant", req_ready, 1);
        step(1, 0, 4, 3, 0); chk("s_new_limit_grant", req_ready, 1);
        step(1, 0, 4, 0, 6); chk("s_old_limit_stall", req_ready, 0);
        step(1, 0, 4, 3, 0); chk("s_new_limit_next", req_ready, 1);

        // Non-posted header counter wraps through 0xFFE -> 0x005
        step(0, 0, 0, 5, 0);
        step(0, 0, 0, 1, 100);
        for (int i = 0; i < 4094; i++) step(1, 1, 0, 1, (i + 100) & 'hFFF);
        step(0, 1, 0, 1, 5);
        for (int k = 0; k < 7; k++) begin
            step(1, 1, 0, 3, 0); chk("w_grant_across_wrap", req_ready, 1);
        end
        step(1, 1, 0, 3, 0); chk("w_exhausted", req_ready, 0);

        // Reserved type never granted
        step(1, 3, 0, 3, 0); chk("r_type3", req_ready, 0);

        // Reset mid-burst
        step(0, 0, 0, 0, 100);
        step(0, 0, 0, 4, 1000);
        step(1, 0, 8, 3, 0); chk("x_pre_reset", req_ready, 1);
        rst = 1'b1;
        step(1, 0, 8, 3, 0);
        chk("x_ready", req_ready, 0); chk("x_lv", limit_valid, 0); chk("x_sc", stall_count, 0);
        rst = 1'b0;
        step(1, 0, 8, 0, 100); chk("x_no_pd", req_ready, 0); chk("x_sc1", stall_count, 1);
        step(1, 0, 8, 3, 0);   chk("x_ph_only", req_ready, 0);
        step(1, 0, 8, 4, 1000); chk("x_pd_capture", req_ready, 0);
        step(1, 0, 8, 3, 0);   chk("x_regrant", req_ready, 1);
        step(0, 0, 0, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
